// File: rtl/pe_weight_reader_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg : shared definitions for the PE weight reader.
//   - pe_state_e     : reader FSM states (IDLE, READY, WAIT, DONE)
//   - PE_MEM_LAT_MAX : largest memory read latency the reader supports
//   - PE_LAT_W       : width of the latency down-counter
// ---------------------------------------------------------------------------
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } pe_state_e;

    localparam int PE_MEM_LAT_MAX = 4;

    // The counter has to hold PE_MEM_LAT_MAX itself, not just MAX-1.
    localparam int PE_LAT_W = $clog2(PE_MEM_LAT_MAX + 1);

endpackage

// File: rtl/pe_weight_reader_lat_cnt.sv
// ---------------------------------------------------------------------------
// pe_rd_lat_cnt : loadable down-counter that tracks the memory read latency.
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset (count -> 0)
//   load_i      load load_val_i (has priority over counting)
//   load_val_i  value to load
//   en_i        count down while nonzero
//   lat_done_o  count is zero
// ---------------------------------------------------------------------------
module pe_rd_lat_cnt
    import pe_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [PE_LAT_W-1:0] load_val_i,
    input  logic                en_i,
    output logic                lat_done_o
);

    logic [PE_LAT_W-1:0] cnt_q;
    logic [PE_LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lat_done_o = (cnt_q == '0);

endmodule

// File: rtl/pe_weight_reader.sv
// ---------------------------------------------------------------------------
// pe_weight_reader : fetches one packed word per controller isRead request
// from the weight memory, waits the fixed memory latency, presents the word
// on data_out with a one-cycle readyToPick pulse, and raises readDone after
// the last word of the armed fold.
//
// Optional feature macro: PE_READER_PROTCHK_EN adds the sticky proto_err
// output (isRead outside READY, or a fold that wraps the address space).
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start, base_addr,
//   num_words                arm a new fold (aborts any in-flight fetch)
//   isRead                   request for the next word (level)
//   readyToPick, data_out    one-cycle pulse + captured word
//   readDone                 fold complete (level)
//   mem_en, mem_addr,
//   mem_rdata                memory read port
//   proto_err                (macro only) sticky protocol error
//   dbg_state                current FSM state, for observation
//
// Handshake: a fetch is issued only when isRead is high at a clock edge
// while in READY; readyToPick is high for exactly one cycle and data_out
// holds its value until the next capture.
// ---------------------------------------------------------------------------
module pe_weight_reader
    import pe_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2      // legal 1..PE_MEM_LAT_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              isRead,
    output logic              readyToPick,
    output logic              readDone,
    output logic [DATA_W-1:0] data_out,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef PE_READER_PROTCHK_EN
    output logic              proto_err,
`endif
    output logic [1:0]        dbg_state
);

    pe_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] idx_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rtp_q, rtp_d;
    logic              done_q, done_d;
    logic              men_q, men_d;
    logic              lat_load;
    logic              lat_done;

    pe_rd_lat_cnt u_lat_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (lat_load),
        .load_val_i (PE_LAT_W'(MEM_LAT)),
        .en_i       (state_q == WAIT),
        .lat_done_o (lat_done)
    );

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        num_d    = num_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = done_q;
        rtp_d    = 1'b0;
        men_d    = 1'b0;
        lat_load = 1'b0;

        if (start) begin
            // start wins over everything: any in-flight word is dropped
            // and a same-cycle isRead is not honoured.
            if (num_words == '0) begin
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                base_d  = base_addr;
                num_d   = num_words;
                idx_d   = '0;
                done_d  = 1'b0;
                state_d = READY;
            end
        end else begin
            case (state_q)
                READY: begin
                    if (isRead) begin
                        men_d    = 1'b1;
                        addr_d   = base_q + idx_q;  // wraps modulo 2^ADDR_W
                        lat_load = 1'b1;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    // Counter hits zero during the cycle mem_rdata is valid.
                    if (lat_done) begin
                        data_d = mem_rdata;
                        rtp_d  = 1'b1;
                        idx_d  = idx_inc;
                        if (idx_inc == num_q) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = READY;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE wait for start; isRead is ignored.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rtp_q   <= 1'b0;
            done_q  <= 1'b0;
            men_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rtp_q   <= rtp_d;
            done_q  <= done_d;
            men_q   <= men_d;
        end
    end

`ifdef PE_READER_PROTCHK_EN
    logic              perr_q, perr_d;
    logic [ADDR_W:0]   fold_end;

    // A fold wraps when base + count runs past the top of the address space.
    assign fold_end = {1'b0, base_addr} + {1'b0, num_words};

    always_comb begin
        perr_d = perr_q;
        if (isRead && (state_q != READY)) begin
            perr_d = 1'b1;
        end
        if (start && (fold_end > {1'b1, {ADDR_W{1'b0}}})) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign proto_err = perr_q;
`endif

    assign readyToPick = rtp_q;
    assign readDone    = done_q;
    assign data_out    = data_q;
    assign mem_en      = men_q;
    assign mem_addr    = addr_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pe_weight_reader.sv
// ---------------------------------------------------------------------------
// tb_pe_weight_reader : directed bench for pe_weight_reader (MEM_LAT = 2).
// Drivers push expected fetch addresses and expected words into queues; a
// monitor on the falling edge pops and compares whenever mem_en or
// readyToPick is seen, including the cycle on which it was due.
// ---------------------------------------------------------------------------
module tb_pe_weight_reader;

  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic          isRead = 1'b0;
  logic          readyToPick;
  logic          readDone;
  logic [DW-1:0] data_out;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;
`ifdef PE_READER_PROTCHK_EN
  logic          proto_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // {due cycle, address}
  logic [41:0] addr_q[$];
  // {readDone, due cycle, data}
  logic [96:0] exp_q[$];

  pe_weight_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .isRead      (isRead),
    .readyToPick (readyToPick),
    .readDone    (readDone),
    .data_out    (data_out),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
`ifdef PE_READER_PROTCHK_EN
    .proto_err   (proto_err),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model (2-cycle latency) ----------------
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return 64'hF00D_0000_0000_0000 | ({54'd0, a} << 20) | {54'd0, ~a};
  endfunction

  logic          v1 = 1'b0, v2 = 1'b0;
  logic [AW-1:0] a1 = '0;
  logic [DW-1:0] d2 = '0;
  always @(posedge clk) begin
    v1 <= mem_en;
    a1 <= mem_addr;
    v2 <= v1;
    d2 <= mem_f(a1);
  end
  assign mem_rdata = v2 ? d2 : 64'hBAD0_BAD0_BAD0_BAD0;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (mem_en) begin
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_en: addr %h at cycle %0d, none expected", mem_addr, cyc);
        end else begin
          logic [41:0] ea;
          ea = addr_q.pop_front();
          chk("mem_addr", {54'd0, mem_addr}, {54'd0, ea[9:0]});
          chk("mem_en_cycle", 64'(cyc), {32'd0, ea[41:10]});
        end
      end
      if (readyToPick) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_readyToPick: data %h at cycle %0d, none expected", data_out, cyc);
        end else begin
          logic [96:0] ed;
          ed = exp_q.pop_front();
          chk("data_out", data_out, ed[63:0]);
          chk("rtp_cycle", 64'(cyc), {32'd0, ed[95:64]});
          chk("readDone_at_rtp", {63'd0, readDone}, {63'd0, ed[96]});
        end
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    start = 1'b1;
    base_addr = b;
    num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issue one isRead, queue its expectations, wait for readyToPick.
  task automatic read_word(input logic [AW-1:0] a, input logic last);
    int c;
    bit got;
    c = cyc;
    isRead = 1'b1;
    addr_q.push_back({32'(c + 1), a});
    exp_q.push_back({last, 32'(c + 4), mem_f(a)});
    @(negedge clk);
    isRead = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (readyToPick) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rtp_timeout: no readyToPick for addr %h", a);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, {62'd0, dbg_state}, 64'd0);
    chk({tag, "_rtp"}, {63'd0, readyToPick}, 64'd0);
    chk({tag, "_readDone"}, {63'd0, readDone}, 64'd0);
    chk({tag, "_mem_en"}, {63'd0, mem_en}, 64'd0);
    chk({tag, "_data_out"}, data_out, 64'd0);
    chk({tag, "_mem_addr"}, {54'd0, mem_addr}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // power-on reset
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_all_zero("reset");
`ifdef PE_READER_PROTCHK_EN
    chk("proto_reset", {63'd0, proto_err}, 64'd0);
`endif

    // 3-word fold at 0x010
    do_start(10'h010, 10'd3);
    chk("fold3_state", {62'd0, dbg_state}, 64'd1);
    chk("fold3_done_lo", {63'd0, readDone}, 64'd0);
    read_word(10'h010, 1'b0);
    read_word(10'h011, 1'b0);
    read_word(10'h012, 1'b1);
    @(negedge clk);
    chk("fold3_done_hold", {63'd0, readDone}, 64'd1);
    chk("fold3_state_done", {62'd0, dbg_state}, 64'd3);
`ifdef PE_READER_PROTCHK_EN
    chk("proto_clean", {63'd0, proto_err}, 64'd0);
`endif

    // empty fold: done at once, isRead ignored
    do_start(10'h055, 10'd0);
    chk("empty_done", {63'd0, readDone}, 64'd1);
    chk("empty_state", {62'd0, dbg_state}, 64'd3);
    isRead = 1'b1;
    repeat (6) @(negedge clk);
    isRead = 1'b0;
    chk("empty_done_hold", {63'd0, readDone}, 64'd1);
`ifdef PE_READER_PROTCHK_EN
    chk("proto_read_in_done", {63'd0, proto_err}, 64'd1);
    do_reset();
    chk("proto_cleared", {63'd0, proto_err}, 64'd0);
`endif

    // wrapping fold
    do_start(10'h3FE, 10'd4);
`ifdef PE_READER_PROTCHK_EN
    chk("proto_wrap", {63'd0, proto_err}, 64'd1);
`endif
    read_word(10'h3FE, 1'b0);
    read_word(10'h3FF, 1'b0);
    read_word(10'h000, 1'b0);
    read_word(10'h001, 1'b1);

    // isRead held high for a 2-word fold
    do_start(10'h100, 10'd2);
    begin
      int c;
      c = cyc;
      isRead = 1'b1;
      addr_q.push_back({32'(c + 1), 10'h100});
      exp_q.push_back({1'b0, 32'(c + 4), mem_f(10'h100)});
      addr_q.push_back({32'(c + 5), 10'h101});
      exp_q.push_back({1'b1, 32'(c + 8), mem_f(10'h101)});
      repeat (14) @(negedge clk);
      isRead = 1'b0;
    end
    chk("held_done", {63'd0, readDone}, 64'd1);

    // abort during WAIT of word 1
    do_start(10'h020, 10'd2);
    read_word(10'h020, 1'b0);
    begin
      int c;
      c = cyc;
      isRead = 1'b1;
      addr_q.push_back({32'(c + 1), 10'h021});
      @(negedge clk);
      isRead = 1'b0;
      @(negedge clk);
      do_start(10'h040, 10'd1);
    end
    chk("abort_state", {62'd0, dbg_state}, 64'd1);
    chk("abort_data_kept", data_out, mem_f(10'h020));
    repeat (4) @(negedge clk);
    chk("abort_data_kept2", data_out, mem_f(10'h020));
    chk("abort_done_lo", {63'd0, readDone}, 64'd0);
    read_word(10'h040, 1'b1);

    // reset during WAIT
    do_start(10'h080, 10'd2);
    begin
      int c;
      c = cyc;
      isRead = 1'b1;
      addr_q.push_back({32'(c + 1), 10'h080});
      @(negedge clk);
      isRead = 1'b0;
      @(negedge clk);
      do_reset();
    end
    chk_all_zero("midrst");
    isRead = 1'b1;
    repeat (6) @(negedge clk);
    isRead = 1'b0;
    chk("midrst_idle", {62'd0, dbg_state}, 64'd0);
    chk("midrst_no_rtp", {63'd0, readyToPick}, 64'd0);

    // all queued expectations consumed
    repeat (3) @(negedge clk);
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
